hazard_ctrl: RTL and testbench

Pipeline interlock and sequencing controller for the decode stage. Tracks outstanding register writes in a per-register scoreboard and stalls IF and ID while a decoded instruction reads a register whose write has not yet reached WB. Inserts bubbles into ID/EX and squashes the wrong-path IF/ID instruction after a taken D-type redirect (BRA/CALL) resolved in ID. Sits beside `id_stage`, fed by ID decode fields and the WB write port, driving the IF/ID and ID/EX register enables.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_scoreboard.sv | 53 +++++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared decode-stage types: register addresses, scoreboard counters, interlock FSM states.
// Imported by hazard_ctrl and its scoreboard.
package types;
  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] u32_t;
  typedef logic [1:0]  sbcnt_t;

  typedef enum logic [1:0] {
    HZ_RESET,
    HZ_RUN,
    HZ_STALL,
    HZ_FLUSH
  } hz_state_e;

  localparam int HZ_MAX_INFLIGHT = 3;
endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register outstanding-write counters (r1..r31); lookups are combinational off the registered counts.
// Increments/decrements land one cycle after the issue/WB edge; a WB to an idle register sets a sticky error.
module scoreboard
  import types::*;
#(
  parameter int MAX_INFLIGHT = HZ_MAX_INFLIGHT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc_vld,
  input  regaddr_t inc_addr,
  input  logic     dec_vld,
  input  regaddr_t dec_addr,
  input  regaddr_t ra_addr,
  input  regaddr_t rb_addr,
  input  regaddr_t rd_addr,
  output logic     ra_busy,
  output logic     rb_busy,
  output logic     rd_full,
  output u32_t     busy_mask,
  output logic     sb_error
);

  // Entry 0 is never written after reset, so r0 lookups always read idle.
  sbcnt_t cnt [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc_vld && inc_addr == regaddr_t'(i) && !(dec_vld && dec_addr == regaddr_t'(i)))
          cnt[i] <= cnt[i] + 2'd1;
        else if (dec_vld && dec_addr == regaddr_t'(i) && !(inc_vld && inc_addr == regaddr_t'(i))
                 && cnt[i] != '0)
          cnt[i] <= cnt[i] - 2'd1;
      end
      if (dec_vld && dec_addr != '0 && cnt[dec_addr] == '0)
        sb_error <= 1'b1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < 32; i++) busy_mask[i] = (cnt[i] != '0);
  end

  assign ra_busy = (ra_addr != '0) && (cnt[ra_addr] != '0);
  assign rb_busy = (rb_addr != '0) && (cnt[rb_addr] != '0);
  assign rd_full = (rd_addr != '0) && (cnt[rd_addr] == sbcnt_t'(MAX_INFLIGHT));

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: stalls IF/ID on RAW or full-scoreboard hazards, bubbles ID/EX, flushes after redirects.
// Controls are combinational in the same cycle; a stalled instruction issues the cycle after its last producer's WB.
module hazard_ctrl
  import types::*;
#(
  parameter int MAX_INFLIGHT = HZ_MAX_INFLIGHT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     id_valid,
  input  regaddr_t id_ra_addr,
  input  regaddr_t id_rb_addr,
  input  regaddr_t id_rd_addr,
  input  logic     id_ra_used,
  input  logic     id_rb_used,
  input  logic     id_redirect,
  input  logic     wb_valid,
  input  regaddr_t wb_rd_addr,
  output logic     stall_if,
  output logic     stall_id,
  output logic     insert_bubble,
  output logic     flush_ifid,
  output u32_t     busy_mask,
  output logic     sb_error,
  output u32_t     stall_count
);

  hz_state_e state, state_nxt;
  logic      ra_busy, rb_busy, rd_full;
  logic      hazard, issue;

  scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_vld   (issue && id_rd_addr != '0),
    .inc_addr  (id_rd_addr),
    .dec_vld   (wb_valid && wb_rd_addr != '0),
    .dec_addr  (wb_rd_addr),
    .ra_addr   (id_ra_addr),
    .rb_addr   (id_rb_addr),
    .rd_addr   (id_rd_addr),
    .ra_busy   (ra_busy),
    .rb_busy   (rb_busy),
    .rd_full   (rd_full),
    .busy_mask (busy_mask),
    .sb_error  (sb_error)
  );

  assign hazard = id_valid && ((id_ra_used && ra_busy) || (id_rb_used && rb_busy) || rd_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HZ_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    insert_bubble = 1'b0;
    flush_ifid    = 1'b0;
    issue         = 1'b0;
    case (state)
      HZ_RESET: begin
        stall_if      = 1'b1;
        stall_id      = 1'b1;
        insert_bubble = 1'b1;
        state_nxt     = HZ_RUN;
      end
      HZ_RUN, HZ_STALL: begin
        if (hazard) begin
          stall_if      = 1'b1;
          stall_id      = 1'b1;
          insert_bubble = 1'b1;
          state_nxt     = HZ_STALL;
        end else begin
          // A stall that just cleared issues this cycle exactly like RUN.
          issue     = id_valid;
          state_nxt = (id_valid && id_redirect) ? HZ_FLUSH : HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        flush_ifid    = 1'b1;
        insert_bubble = 1'b1;
        state_nxt     = HZ_RUN;
      end
      default: state_nxt = HZ_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (state == HZ_STALL && stall_count != 32'hFFFF_FFFF)
      stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized stimulus against a counter-per-register reference model of the interlock rules.
module tb_hazard_ctrl;
  import types::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b1;
  logic     id_valid = 1'b0;
  regaddr_t id_ra_addr = '0, id_rb_addr = '0, id_rd_addr = '0;
  logic     id_ra_used = 1'b0, id_rb_used = 1'b0, id_redirect = 1'b0;
  logic     wb_valid = 1'b0;
  regaddr_t wb_rd_addr = '0;
  logic     stall_if, stall_id, insert_bubble, flush_ifid, sb_error;
  u32_t     busy_mask, stall_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr), .id_rd_addr(id_rd_addr),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_redirect(id_redirect),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .stall_if(stall_if), .stall_id(stall_id), .insert_bubble(insert_bubble),
    .flush_ifid(flush_ifid), .busy_mask(busy_mask), .sb_error(sb_error),
    .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding writes per register plus "what kind of cycle is this".
  int          m_cnt [32];
  bit          m_reset_cycle, m_flush_cycle, m_stall_cycle, m_err;
  longint      m_stalls;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_reset_cycle = 1; m_flush_cycle = 0; m_stall_cycle = 0; m_err = 0; m_stalls = 0;
  endtask

  // One clock cycle: drive, check combinational/registered outputs mid-cycle, advance the model.
  task automatic cyc(input bit v, input int ra, input bit rau, input int rb, input bit rbu,
                     input int rd, input bit redir, input bit wv, input int wrd);
    bit hz, issue, inc, dec;
    bit e_sif, e_sid, e_bub, e_fl;
    logic [31:0] e_mask;
    id_valid = v; id_ra_addr = regaddr_t'(ra); id_ra_used = rau;
    id_rb_addr = regaddr_t'(rb); id_rb_used = rbu; id_rd_addr = regaddr_t'(rd);
    id_redirect = redir; wb_valid = wv; wb_rd_addr = regaddr_t'(wrd);
    if (!rst_n) model_reset();
    @(negedge clk);
    hz = v && ((rau && ra != 0 && m_cnt[ra] != 0) || (rbu && rb != 0 && m_cnt[rb] != 0) ||
               (rd != 0 && m_cnt[rd] == 3));
    e_fl = 0;
    if (m_reset_cycle)      begin e_sif = 1; e_sid = 1; e_bub = 1; end
    else if (m_flush_cycle) begin e_sif = 0; e_sid = 0; e_bub = 1; e_fl = 1; end
    else                    begin e_sif = hz; e_sid = hz; e_bub = hz; end
    e_mask = '0;
    for (int i = 1; i < 32; i++) e_mask[i] = (m_cnt[i] != 0);
    check_val("stall_if", 32'(stall_if), 32'(e_sif));
    check_val("stall_id", 32'(stall_id), 32'(e_sid));
    check_val("insert_bubble", 32'(insert_bubble), 32'(e_bub));
    check_val("flush_ifid", 32'(flush_ifid), 32'(e_fl));
    check_val("busy_mask", busy_mask, e_mask);
    check_val("sb_error", 32'(sb_error), 32'(m_err));
    check_val("stall_count", stall_count, (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls));
    @(posedge clk);
    if (rst_n) begin
      issue = !m_reset_cycle && !m_flush_cycle && v && !hz;
      if (m_stall_cycle) m_stalls++;
      inc = issue && rd != 0;
      dec = wv && wrd != 0;
      if (dec && m_cnt[wrd] == 0) m_err = 1;
      if (!(inc && dec && rd == wrd)) begin
        if (inc) m_cnt[rd]++;
        if (dec && m_cnt[wrd] > 0) m_cnt[wrd]--;
      end
      m_stall_cycle = !m_reset_cycle && !m_flush_cycle && hz;
      m_flush_cycle = issue && redir;
      m_reset_cycle = 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 5;
      2: return 7;
      3: return 9;
      default: return $urandom_range(0, 31);
    endcase
  endfunction

  function automatic int pick_busy();
    int s = $urandom_range(1, 31);
    for (int i = 0; i < 31; i++) begin
      if (m_cnt[1 + (s + i) % 31] != 0) return 1 + (s + i) % 31;
    end
    return pick_reg();
  endfunction

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // RAW on r5: reader stalls through the WB cycle, issues the next one.
    cyc(1, 0, 0, 0, 0, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 5, 1, 0, 0, 6, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 6, 0, 1, 5);
    cyc(1, 5, 1, 0, 0, 6, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6);

    // r0 destination, r0 source and unused operand never stall.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc(1, 0, 1, 5, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 1, 0, 0, 1, 5);

    // Redirect: flush cycle must not increment r8.
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 8, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3);

    // Capacity on r7, then collisions between issue and WB.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 7, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 0, 1, 7);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);

    // Spurious WB, then reset while stalled.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cyc(1, 0, 0, 0, 0, 4, 0, 0, 0);
    cyc(1, 0, 0, 4, 1, 2, 1, 0, 0);
    cyc(1, 0, 0, 4, 1, 2, 1, 0, 0);
    rst_n = 1'b0;
    cyc(1, 0, 0, 4, 1, 2, 1, 0, 0);
    rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      bit wv;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      wv = ($urandom_range(0, 99) < 45);
      cyc($urandom_range(0, 9) < 8, pick_reg(), $urandom_range(0, 1), pick_reg(), $urandom_range(0, 1),
          pick_reg(), $urandom_range(0, 4) == 0, wv,
          ($urandom_range(0, 9) < 9) ? pick_busy() : pick_reg());
    end
    rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
